spi_master_reader: RTL and testbench
====================================

Name: spi_master_reader

Overview:
- SPI mode-0 master: the other end of the tracking-data SPI link.
- Drives cs/sclk/mosi and shifts in one 32-bit frame per transaction on miso.
- Unpacks the frame into xdata/ydata/etc and pulses rx_valid once the frame is complete.
- Sits on the consumer board and feeds the tracking-motor control logic.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period; minimum 2.
- CS_SETUP, 2: sclk half-periods between cs falling and the first sclk rising edge; minimum 1.
- CS_HOLD, 2: sclk half-periods between the last sclk falling edge and cs rising; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle transaction request; sampled only in IDLE
- tx_word  in  32  word shifted out on mosi, MSB first; captured on start acceptance
- sclk  out  1  SPI clock; idles low
- mosi  out  1  master data out
- miso  in  1  slave data in
- cs  out  1  chip select, active-low
- busy  out  1  high from start acceptance until the cycle after DONE
- rx_valid  out  1  one-cycle pulse when the outputs below update
- rx_frame  out  32  raw received frame
- xdata  out  10  rx_frame[31:22]
- ydata  out  9  rx_frame[21:13]
- etc  out  13  rx_frame[12:0]

Behaviour:
- Reset (asynchronous, active-low):
  - cs=1, sclk=0, mosi=0, busy=0, rx_valid=0.
  - rx_frame, xdata, ydata, etc = 0.
  - FSM returns to IDLE.
  - Asserting reset mid-frame aborts the frame immediately; no rx_valid is produced for it.
- All outputs are registered.
- Divider:
  - Counter runs 0..CLK_DIV-1 only outside IDLE.
  - A tick fires when it reaches CLK_DIV-1, then it wraps to 0.
  - The counter clears on every state entry.
- FSM states:
  - IDLE: start=1 causes entry to SETUP on the next edge. At that edge: cs=0, busy=1, tx_word latched into the shift register, mosi = tx_word[31].
  - SETUP: count CS_SETUP ticks, then go to XFER.
  - XFER: each tick toggles sclk.
    - Rising edge (sclk 0->1): shift miso into the rx shift register LSB; the bit counter increments.
    - Falling edge (sclk 1->0): if bit count < 32, present the next tx bit on mosi.
    - After the 32nd falling edge (64 ticks total), go to HOLD with sclk=0.
  - HOLD: count CS_HOLD ticks, then go to DONE with cs=1.
  - DONE: one cycle. rx_valid=1; rx_frame, xdata, ydata, etc loaded from the rx shift register. Next state IDLE. busy drops on the IDLE entry edge.
- Latency: start acceptance to rx_valid = (CS_SETUP + 64 + CS_HOLD) × CLK_DIV + 1 clk cycles.
  - For the defaults: 273.
- Boundary conditions:
  - start while busy: ignored (no queuing).
  - start in the same cycle as DONE: ignored; start is accepted only in IDLE.
  - miso is sampled exactly once per rising edge. Bit order is MSB first: the first sampled bit lands in rx_frame[31].
  - xdata, ydata, etc hold their last values until the next DONE.

Optional Feature:
- Macro: SPI_MASTER_AUTO_POLL_EN.
- When defined:
  - Adds parameter POLL_PERIOD (default 100000 clk cycles).
  - A free-running counter issues an internal start every POLL_PERIOD cycles. The internal start is ORed with the start port and ignored while busy.
  - The counter reloads on each internal-start pulse and counts through busy.
  - tx_word is sampled as usual.
- When undefined: transactions start only from the start port; there is no counter logic.

Decomposition:
- Package spi_link_pkg holds:
  - FRAME_BITS=32.
  - Field constants X_MSB=31, X_LSB=22, Y_MSB=21, Y_LSB=13, ETC_MSB=12, ETC_LSB=0.
  - FSM enum state_t {IDLE, SETUP, XFER, HOLD, DONE}.
  - The same package also serves the slave-side frame packer.
- One sub-module, spi_sclk_div: divider counter and tick generation, with enable and clear inputs.

Test Plan:
1. Reset release, no start -> cs=1, sclk=0, busy=0, rx_valid never pulses over 1000 cycles.
2. Defaults; slave model returns 0xA5C31E7F; start with tx_word=0x12345678 ->
   - rx_valid at acceptance+273 cycles.
   - rx_frame=0xA5C31E7F, xdata=0x297, ydata=0x018, etc=0x1E7F.
   - Slave captures 0x12345678 on mosi.
   - Exactly 32 sclk rising edges while cs=0.
3. start re-pulsed at cycles +10 and +200 of an active frame -> ignored; one rx_valid only; next start after busy=0 begins a new frame.
4. reset asserted at bit 15 -> cs=1, sclk=0 immediately; outputs=0; no rx_valid. A subsequent start completes normally with frame 0xFFFFFFFF -> xdata=0x3FF, ydata=0x1FF, etc=0x1FFF.
5. CLK_DIV=2, CS_SETUP=1, CS_HOLD=1 -> latency 133 cycles; sclk period 4 clk cycles; frame 0x00000001 -> etc=1, xdata=0, ydata=0.
6. SPI_MASTER_AUTO_POLL_EN, POLL_PERIOD=500, defaults -> rx_valid pulses every 500 cycles with no start-port activity.

Source files
------------

// File: rtl/spi_link_pkg.sv
// Shared definitions for the tracking-data SPI link.
// The master-side reader and the slave-side frame packer both use this package.
package spi_link_pkg;

    localparam int FRAME_BITS = 32;

    // Frame field positions
    localparam int X_MSB   = 31;
    localparam int X_LSB   = 22;
    localparam int Y_MSB   = 21;
    localparam int Y_LSB   = 13;
    localparam int ETC_MSB = 12;
    localparam int ETC_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK half-period divider for the SPI master.
// Counts 0..CLK_DIV-1 while enabled and emits a one-cycle tick on the last count.
// A clear (or a disable) forces the count back to zero.
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

    // Next count: wrap on tick, zero when idle or on state entry.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_reader.sv
// SPI mode-0 master that reads one 32-bit tracking frame per transaction
// and unpacks it into xdata / ydata / etc.
// Optional build macro SPI_MASTER_AUTO_POLL_EN adds a free-running poll timer
// (parameter POLL_PERIOD) that issues a start request every POLL_PERIOD cycles.
module spi_master_reader
    import spi_link_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
`ifdef SPI_MASTER_AUTO_POLL_EN
    ,
    parameter int POLL_PERIOD = 100000
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_word,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs,
    output logic                  busy,
    output logic                  rx_valid,
    output logic [FRAME_BITS-1:0] rx_frame,
    output logic [9:0]            xdata,
    output logic [8:0]            ydata,
    output logic [12:0]           etc
);

    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BW     = $clog2(FRAME_BITS + 1);

    state_t                state_q, state_d;
    logic [PW-1:0]         ph_q, ph_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-2:0] tx_sh_q, tx_sh_d;
    logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [FRAME_BITS-1:0] rx_frame_q, rx_frame_d;

    logic tick;
    logic div_en;
    logic div_clr;
    logic start_req;

`ifdef SPI_MASTER_AUTO_POLL_EN
    localparam int PCW = $clog2(POLL_PERIOD);

    logic [PCW-1:0] poll_q, poll_d;
    logic           poll_tick;

    assign poll_tick = (poll_q == PCW'(POLL_PERIOD - 1));
    assign start_req = start | poll_tick;

    // Poll timer reloads on its own pulse and keeps running through transfers.
    always_comb begin
        poll_d = poll_tick ? '0 : poll_q + PCW'(1);
    end

    // Poll timer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_d;
        end
    end
`else
    assign start_req = start;
`endif

    // The divider only runs while a transaction is in progress and restarts on
    // every state change so each phase begins with a full half-period.
    assign div_en  = (state_q != IDLE);
    assign div_clr = (state_d != state_q);

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (div_en),
        .clr_i  (div_clr),
        .tick_o (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_req) state_d = SETUP;
            SETUP: if (tick && (ph_q == PW'(CS_SETUP - 1))) state_d = XFER;
            XFER:  if (tick && sclk_q && (bit_q == BW'(FRAME_BITS))) state_d = HOLD;
            HOLD:  if (tick && (ph_q == PW'(CS_HOLD - 1))) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values for the registered outputs.
    always_comb begin
        ph_d       = ph_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_frame_d = rx_frame_q;

        if (state_d != state_q) begin
            ph_d = '0;
        end else if (tick && ((state_q == SETUP) || (state_q == HOLD))) begin
            ph_d = ph_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    mosi_d  = tx_word[FRAME_BITS-1];
                    tx_sh_d = tx_word[FRAME_BITS-2:0];
                end
            end
            XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: sample the slave, MSB arrives first.
                        rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], miso};
                        bit_d   = bit_q + BW'(1);
                    end else if (bit_q < BW'(FRAME_BITS)) begin
                        // Falling edge: present the next outgoing bit.
                        mosi_d  = tx_sh_q[FRAME_BITS-2];
                        tx_sh_d = {tx_sh_q[FRAME_BITS-3:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                if (state_d == DONE) begin
                    cs_d = 1'b1;
                end
            end
            DONE: begin
                rx_valid_d = 1'b1;
                rx_frame_d = rx_sh_q;
                busy_d     = 1'b0;
            end
            default: ;
        endcase
    end

    // Control and output registers; a reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q       <= '0;
            bit_q      <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_frame_q <= '0;
        end else begin
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_frame_q <= rx_frame_d;
        end
    end

    // Shift registers are fully reloaded every frame, so they carry no reset.
    always_ff @(posedge clk) begin
        tx_sh_q <= tx_sh_d;
        rx_sh_q <= rx_sh_d;
    end

    assign cs       = cs_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign busy     = busy_q;
    assign rx_valid = rx_valid_q;
    assign rx_frame = rx_frame_q;
    assign xdata    = rx_frame_q[X_MSB:X_LSB];
    assign ydata    = rx_frame_q[Y_MSB:Y_LSB];
    assign etc      = rx_frame_q[ETC_MSB:ETC_LSB];

endmodule

// File: tb/tb_spi_master_reader.sv
// Self-checking bench for spi_master_reader: a default-parameter instance (A),
// a fast instance (B: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1) and, when
// SPI_MASTER_AUTO_POLL_EN is defined, an auto-polling instance (C).
module tb_spi_master_reader;

    typedef struct {
        logic [31:0] frame;
        logic [31:0] tx;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    exp_t qA[$];
    exp_t qB[$];

    // Instance A signals
    logic        startA, sclkA, mosiA, misoA, csA, busyA, rxvA;
    logic [31:0] txA, rxfA;
    logic [9:0]  xA;
    logic [8:0]  yA;
    logic [12:0] eA;

    // Instance B signals
    logic        startB, sclkB, mosiB, misoB, csB, busyB, rxvB;
    logic [31:0] txB, rxfB;
    logic [9:0]  xB;
    logic [8:0]  yB;
    logic [12:0] eB;

    // Slave models
    logic [31:0] sA_frame = '0, sA_cap = '0;
    logic [5:0]  sA_rise = '0;
    logic [31:0] sB_frame = '0, sB_cap = '0;
    logic [5:0]  sB_rise = '0;
    int          sB_t0 = 0, sB_t1 = 0;

    int vA_cnt = 0;
    int csA_low = 0;

    spi_master_reader dutA (
        .clk(clk), .reset(rst_n), .start(startA), .tx_word(txA),
        .sclk(sclkA), .mosi(mosiA), .miso(misoA), .cs(csA), .busy(busyA),
        .rx_valid(rxvA), .rx_frame(rxfA), .xdata(xA), .ydata(yA), .etc(eA)
    );

    spi_master_reader #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dutB (
        .clk(clk), .reset(rst_n), .start(startB), .tx_word(txB),
        .sclk(sclkB), .mosi(mosiB), .miso(misoB), .cs(csB), .busy(busyB),
        .rx_valid(rxvB), .rx_frame(rxfB), .xdata(xB), .ydata(yB), .etc(eB)
    );

`ifdef SPI_MASTER_AUTO_POLL_EN
    logic        sclkC, mosiC, csC, busyC, rxvC;
    logic [31:0] rxfC;
    logic [9:0]  xC;
    logic [8:0]  yC;
    logic [12:0] eC;
    int          vC_cnt = 0, vC_last = 0, vC_prev = 0;

    spi_master_reader #(.POLL_PERIOD(500)) dutC (
        .clk(clk), .reset(rst_n), .start(1'b0), .tx_word(32'h0),
        .sclk(sclkC), .mosi(mosiC), .miso(1'b1), .cs(csC), .busy(busyC),
        .rx_valid(rxvC), .rx_frame(rxfC), .xdata(xC), .ydata(yC), .etc(eC)
    );

    always @(posedge clk) begin
        if (rxvC === 1'b1) begin
            vC_cnt  <= vC_cnt + 1;
            vC_last <= cyc;
            vC_prev <= vC_last;
        end
    end
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rxvA === 1'b1) vA_cnt <= vA_cnt + 1;
        if (rst_n && csA === 1'b0) csA_low <= csA_low + 1;
    end

    // Mode-0 slave A: reloads on cs fall, captures mosi on sclk rise,
    // presents frame MSB first (next bit appears after each rising edge).
    always @(negedge csA or posedge sclkA) begin
        if (sclkA) begin
            if (!csA) begin
                sA_cap  <= {sA_cap[30:0], mosiA};
                sA_rise <= sA_rise + 6'd1;
            end
        end else begin
            sA_cap  <= '0;
            sA_rise <= '0;
        end
    end
    assign misoA = sA_rise[5] ? 1'b0 : sA_frame[~sA_rise[4:0]];

    always @(negedge csB or posedge sclkB) begin
        if (sclkB) begin
            if (!csB) begin
                sB_cap  <= {sB_cap[30:0], mosiB};
                sB_rise <= sB_rise + 6'd1;
                if (sB_rise == 6'd0) sB_t0 <= cyc;
                if (sB_rise == 6'd1) sB_t1 <= cyc;
            end
        end else begin
            sB_cap  <= '0;
            sB_rise <= '0;
        end
    end
    assign misoB = sB_rise[5] ? 1'b0 : sB_frame[~sB_rise[4:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit b, input logic [31:0] tx, output int t0);
        @(negedge clk);
        if (b) begin startB = 1'b1; txB = tx; end
        else   begin startA = 1'b1; txA = tx; end
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        t0 = cyc;
    endtask

    // Wait (bounded) for rx_valid, pop the scoreboard and compare.
    task automatic check_frame(input bit b, input int t0, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!(b ? rxvB : rxvA) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(b ? rxvB : rxvA)) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        if ((b ? qB.size() : qA.size()) == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = b ? qB.pop_front() : qA.pop_front();
        chk({tag, "_latency"}, 32'(cyc - t0), 32'(e.lat));
        chk({tag, "_rx_frame"}, b ? rxfB : rxfA, e.frame);
        chk({tag, "_xdata"}, 32'(b ? xB : xA), 32'(e.frame[31:22]));
        chk({tag, "_ydata"}, 32'(b ? yB : yA), 32'(e.frame[21:13]));
        chk({tag, "_etc"},   32'(b ? eB : eA), 32'(e.frame[12:0]));
        chk({tag, "_slave_mosi"}, b ? sB_cap : sA_cap, e.tx);
        chk({tag, "_sclk_rises"}, 32'(b ? sB_rise : sA_rise), 32'd32);
        chk({tag, "_busy_low"}, 32'(b ? busyB : busyA), 32'd0);
        @(negedge clk);
        chk({tag, "_valid_one_cycle"}, 32'(b ? rxvB : rxvA), 32'd0);
        chk({tag, "_cs_high"}, 32'(b ? csB : csA), 32'd1);
    endtask

    initial begin
        int t0;
        int nv;
        int n;
        rst_n  = 1'b0;
        startA = 1'b0; txA = '0;
        startB = 1'b0; txB = '0;
        repeat (3) @(negedge clk);

        // 1: reset state, then idle with no start
        chk("t1_rst_cs", 32'(csA), 32'd1);
        chk("t1_rst_sclk", 32'(sclkA), 32'd0);
        chk("t1_rst_busy", 32'(busyA), 32'd0);
        chk("t1_rst_valid", 32'(rxvA), 32'd0);
        chk("t1_rst_frame", rxfA, 32'd0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("t1_no_valid", 32'(vA_cnt), 32'd0);
        chk("t1_cs_never_low", 32'(csA_low), 32'd0);
        chk("t1_idle_sclk", 32'(sclkA), 32'd0);
        chk("t1_idle_busy", 32'(busyA), 32'd0);

        // 2: nominal frame
        sA_frame = 32'hA5C31E7F;
        qA.push_back('{32'hA5C31E7F, 32'h12345678, 273});
        pulse(1'b0, 32'h12345678, t0);
        chk("t2_busy_on_accept", 32'(busyA), 32'd1);
        chk("t2_cs_on_accept", 32'(csA), 32'd0);
        chk("t2_mosi_msb", 32'(mosiA), 32'd0);
        check_frame(1'b0, t0, "t2");
        chk("t2_xdata_const", 32'(xA), 32'h297);
        chk("t2_ydata_const", 32'(yA), 32'h018);
        chk("t2_etc_const", 32'(eA), 32'h1E7F);

        // 3: start re-pulsed mid-frame and during DONE is ignored
        sA_frame = 32'h3C960F5A;
        qA.push_back('{32'h3C960F5A, 32'hCAFEF00D, 273});
        pulse(1'b0, 32'hCAFEF00D, t0);
        nv = vA_cnt;
        for (int k = 0; k < 3; k++) begin
            int tgt;
            tgt = (k == 0) ? 10 : (k == 1) ? 200 : 272;
            while (cyc < t0 + tgt) @(negedge clk);
            startA = 1'b1;
            txA    = 32'hDEADBEEF;
            @(negedge clk);
            startA = 1'b0;
        end
        check_frame(1'b0, t0, "t3");
        repeat (300) @(negedge clk);
        chk("t3_single_valid", 32'(vA_cnt - nv), 32'd1);
        chk("t3_no_restart_busy", 32'(busyA), 32'd0);
        sA_frame = 32'h0000FFFF;
        qA.push_back('{32'h0000FFFF, 32'h0F0F0F0F, 273});
        pulse(1'b0, 32'h0F0F0F0F, t0);
        check_frame(1'b0, t0, "t3_next");

        // 4: reset at bit 15 aborts the frame
        sA_frame = 32'h13579BDF;
        pulse(1'b0, 32'h55AA55AA, t0);
        nv = vA_cnt;
        n = 0;
        while (sA_rise != 6'd15 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reach_bit15", 32'(sA_rise), 32'd15);
        rst_n = 1'b0;
        #1;
        chk("t4_cs", 32'(csA), 32'd1);
        chk("t4_sclk", 32'(sclkA), 32'd0);
        chk("t4_busy", 32'(busyA), 32'd0);
        chk("t4_mosi", 32'(mosiA), 32'd0);
        chk("t4_frame", rxfA, 32'd0);
        chk("t4_fields", {xA, yA, eA}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("t4_no_valid", 32'(vA_cnt - nv), 32'd0);
        sA_frame = 32'hFFFFFFFF;
        qA.push_back('{32'hFFFFFFFF, 32'h80000001, 273});
        pulse(1'b0, 32'h80000001, t0);
        check_frame(1'b0, t0, "t4_after");
        chk("t4_xdata_const", 32'(xA), 32'h3FF);
        chk("t4_ydata_const", 32'(yA), 32'h1FF);
        chk("t4_etc_const", 32'(eA), 32'h1FFF);

        // 5: fastest divider settings
        sB_frame = 32'h00000001;
        qB.push_back('{32'h00000001, 32'hF0E1D2C3, 133});
        pulse(1'b1, 32'hF0E1D2C3, t0);
        check_frame(1'b1, t0, "t5");
        chk("t5_sclk_period", 32'(sB_t1 - sB_t0), 32'd4);
        chk("t5_etc_const", 32'(eB), 32'd1);
        chk("t5_xy_const", 32'({xB, yB}), 32'd0);

`ifdef SPI_MASTER_AUTO_POLL_EN
        // 6: auto-poll without start-port activity
        nv = vC_cnt;
        n = 0;
        while (vC_cnt < nv + 2 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk("t6_two_polls", 32'(vC_cnt >= nv + 2), 32'd1);
        chk("t6_poll_interval", 32'(vC_last - vC_prev), 32'd500);
        chk("t6_frame", rxfC, 32'hFFFFFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
